// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, data-width encoding, default oversample ratio.
// Pure declarations; no logic or timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    function automatic logic [3:0] data_bits_to_n(input logic [1:0] db);
        logic [3:0] n;
        unique case (db)
            DBITS_5: n = 4'd5;
            DBITS_6: n = 4'd6;
            DBITS_7: n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line front end: 2-flop synchronizer, 3-tap majority filter and start-edge detect.
// Latency: 2 clk sync, taps advance on baud ticks; no backpressure (free-running).
module uart_rx_sync (
    input  logic clk_in,
    input  logic rstn_in,
    input  logic baud_tick_in,
    input  logic rx_in,
    output logic bit_out,
    output logic fall_out
);

    logic [1:0] sync_q, sync_d;
    logic [1:0] tap_q, tap_d;
    logic       smp;

    assign smp = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], rx_in};
        tap_d  = tap_q;
        if (baud_tick_in) begin
            tap_d = {tap_q[0], smp};
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q <= 2'b11;
            tap_q  <= 2'b11;
        end else begin
            sync_q <= sync_d;
            tap_q  <= tap_d;
        end
    end

    // The sample being shifted in on this tick acts as the third tap, so the
    // vote on a tick covers that tick and the two before it.
    assign bit_out  = (tap_q[1] & tap_q[0]) | (tap_q[1] & smp) | (tap_q[0] & smp);
    assign fall_out = baud_tick_in & tap_q[0] & ~smp;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start validation, mid-bit majority sampling, 5-8 data bits, parity, 1-2 stops.
// Latency: word valid 1 clk after the last stop mid-sample tick; backpressure: held word blocks, new frame dropped with overrun pulse.
module uart_rx_deser #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE_DEF
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       baud_tick_in,
    input  logic       rx_in,
    input  logic       lsbfe_in,
    input  logic [1:0] data_bits_in,
    input  logic       parity_en_in,
    input  logic       parity_odd_in,
    input  logic       stop2_in,
    input  logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       parity_err_out,
    output logic       frame_err_out,
    output logic       overrun_out,
    output logic       busy_out
);
    import uart_pkg::*;

    localparam int unsigned   CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_acc_q, par_acc_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          lsbfe_q, lsbfe_d;
    logic [3:0]    nbits_q, nbits_d;
    logic          par_en_q, par_en_d;
    logic          par_odd_q, par_odd_d;
    logic          stop2_q, stop2_d;
    logic [7:0]    data_q, data_d;
    logic          hold_perr_q, hold_perr_d;
    logic          hold_ferr_q, hold_ferr_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          rx_bit, rx_fall;
    logic          mid, eop, last_data, last_stop, complete, load;
    logic [2:0]    data_idx;

    uart_rx_sync u_sync (
        .clk_in       (clk_in),
        .rstn_in      (rstn_in),
        .baud_tick_in (baud_tick_in),
        .rx_in        (rx_in),
        .bit_out      (rx_bit),
        .fall_out     (rx_fall)
    );

    assign mid       = baud_tick_in && (tick_cnt_q == TICK_MID);
    assign eop       = baud_tick_in && (tick_cnt_q == TICK_LAST);
    assign last_data = (bit_cnt_q == 3'(nbits_q - 4'd1));
    assign last_stop = stop2_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd0);
    assign data_idx  = lsbfe_q ? bit_cnt_q : 3'(nbits_q - 4'd1 - {1'b0, bit_cnt_q});
    assign complete  = enable_in && (state_q == ST_STOP) && mid && last_stop;
    assign load      = complete && (!valid_q || ready_in);

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (rx_fall) state_d = ST_START;
                ST_START: begin
                    if (mid && rx_bit) state_d = ST_IDLE;
                    else if (eop)      state_d = ST_DATA;
                end
                ST_DATA:   if (eop && last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
                ST_PARITY: if (eop) state_d = ST_STOP;
                ST_STOP:   if (mid && last_stop) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_acc_d   = par_acc_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        lsbfe_d     = lsbfe_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        stop2_d     = stop2_q;
        data_d      = load ? shift_q : data_q;
        hold_perr_d = load ? perr_q : hold_perr_q;
        hold_ferr_d = load ? (ferr_q | ~rx_bit) : hold_ferr_q;
        valid_d     = load | (valid_q & ~ready_in);
        overrun_d   = complete & ~load;

        if (!enable_in) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (state_q == ST_IDLE) begin
            if (rx_fall) begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                shift_d    = '0;
                par_acc_d  = 1'b0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                lsbfe_d    = lsbfe_in;
                nbits_d    = data_bits_to_n(data_bits_in);
                par_en_d   = parity_en_in;
                par_odd_d  = parity_odd_in;
                stop2_d    = stop2_in;
            end
        end else begin
            if (baud_tick_in) begin
                tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CW'(1);
            end
            unique case (state_q)
                ST_DATA: begin
                    if (mid) begin
                        shift_d[data_idx] = rx_bit;
                        par_acc_d         = par_acc_q ^ rx_bit;
                    end
                    if (eop) bit_cnt_d = last_data ? 3'd0 : bit_cnt_q + 3'd1;
                end
                ST_PARITY: if (mid) perr_d = ((par_acc_q ^ rx_bit) != par_odd_q);
                ST_STOP: begin
                    if (mid) ferr_d = ferr_q | ~rx_bit;
                    if (eop) bit_cnt_d = bit_cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            lsbfe_q     <= 1'b1;
            nbits_q     <= 4'd8;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            data_q      <= '0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            lsbfe_q     <= lsbfe_d;
            nbits_q     <= nbits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            data_q      <= data_d;
            hold_perr_q <= hold_perr_d;
            hold_ferr_q <= hold_ferr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign parity_err_out = hold_perr_q;
    assign frame_err_out  = hold_ferr_q;
    assign overrun_out    = overrun_q;
    assign busy_out       = (state_q != ST_IDLE);

endmodule
